// File: rtl/yuv_to_rgb_convert_if.sv
// Stream channel used between the video pipeline blocks.
// The master drives payload and valid, and the slave drives ready.
interface nasti_stream_channel #(
   parameter int DATA_WIDTH = 64,
   parameter int USER_WIDTH = 1,
   parameter int DEST_WIDTH = 1,
   parameter int ID_WIDTH   = 1
);
   logic                    t_valid;
   logic                    t_ready;
   logic [DATA_WIDTH-1:0]   t_data;
   logic [DATA_WIDTH/8-1:0] t_strb;
   logic [DATA_WIDTH/8-1:0] t_keep;
   logic                    t_last;
   logic [ID_WIDTH-1:0]     t_id;
   logic [DEST_WIDTH-1:0]   t_dest;
   logic [USER_WIDTH-1:0]   t_user;

   modport master (
      output t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
      input  t_ready
   );

   modport slave (
      input  t_valid, t_data, t_strb, t_keep, t_last, t_id, t_dest, t_user,
      output t_ready
   );
endinterface

// File: rtl/yuv_to_rgb_convert.sv
// Packed YUV444 to RGB888 converter with four elastic pipeline stages.
// Stages: S1 capture/offset, S2 multiply, S3 sum/round, S4 clamp/output.
// Each stage has its own valid flag. A stage advances when the stage after it
// is empty or is itself advancing, so full throughput holds under backpressure.
module yuv_to_rgb_convert #(
   parameter int          DATA_WIDTH = 64,
   parameter int          USER_WIDTH = 1,
   parameter int          DEST_WIDTH = 1,
   parameter int          CHAIN_ID   = 0,
   parameter logic [7:0]  ALPHA      = 8'hFF
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic [1:0]                  mode,
   nasti_stream_channel.slave          src,
   nasti_stream_channel.master         dst,
   output logic [15:0]                 frame_count
);
   localparam int PIXELS = DATA_WIDTH / 32;
   localparam int BYTES  = DATA_WIDTH / 8;

   typedef logic signed [31:0] s32_t;

   typedef struct packed {
      s32_t ky;
      s32_t kre;
      s32_t kgu;
      s32_t kge;
      s32_t kbu;
   } coef_t;

   // Sideband state that travels with each beat.
   typedef struct packed {
      logic [1:0]            mode;
      logic                  last;
      logic [USER_WIDTH-1:0] user;
      logic [BYTES-1:0]      keep;
      logic [BYTES-1:0]      strb;
   } side_t;

   function automatic coef_t coef_sel(input logic [1:0] m);
      coef_t k;
      case (m)
         2'd0:    k = '{32'sd298, 32'sd409, 32'sd100, 32'sd208, 32'sd516};
         2'd1:    k = '{32'sd298, 32'sd459, 32'sd55,  32'sd136, 32'sd541};
         2'd2:    k = '{32'sd256, 32'sd359, 32'sd88,  32'sd183, 32'sd454};
         default: k = '0;
      endcase
      return k;
   endfunction

   function automatic logic [7:0] clamp8(input s32_t x);
      logic [7:0] r;
      if (x < 0)
         r = 8'h00;
      else if (x > 32'sd255)
         r = 8'hFF;
      else
         r = x[7:0];
      return r;
   endfunction

   logic  v1, v2, v3, v4;
   logic  adv1, adv2, adv3, out_hs, src_acc;
   s32_t  yoff;
   coef_t k2;

   side_t side1, side2, side3;
   s32_t  c1  [PIXELS];
   s32_t  d1  [PIXELS];
   s32_t  e1  [PIXELS];
   logic [7:0] y1 [PIXELS];
   s32_t  yc2 [PIXELS];
   s32_t  re2 [PIXELS];
   s32_t  gu2 [PIXELS];
   s32_t  ge2 [PIXELS];
   s32_t  bu2 [PIXELS];
   logic [7:0] y2 [PIXELS];
   s32_t  r3  [PIXELS];
   s32_t  g3  [PIXELS];
   s32_t  b3  [PIXELS];
   logic [7:0] y3 [PIXELS];

   logic [DATA_WIDTH-1:0] data4;
   logic [USER_WIDTH-1:0] user4;
   logic [BYTES-1:0]      keep4;
   logic [BYTES-1:0]      strb4;
   logic                  last4;

   // The unused src fields and the ignored top byte of each lane are gathered here.
   logic unused_src;
   assign unused_src = ^{src.t_id, src.t_dest, src.t_data};

   assign out_hs  = v4 && dst.t_ready;
   assign adv3    = v3 && (!v4 || out_hs);
   assign adv2    = v2 && (!v3 || adv3);
   assign adv1    = v1 && (!v2 || adv2);
   assign src.t_ready = !v1 || adv1;
   assign src_acc = src.t_valid && src.t_ready;
   assign yoff    = mode[1] ? 32'sd0 : 32'sd16;
   assign k2      = coef_sel(side1.mode);

   assign dst.t_valid = v4;
   assign dst.t_data  = data4;
   assign dst.t_keep  = keep4;
   assign dst.t_strb  = strb4;
   assign dst.t_last  = last4;
   assign dst.t_user  = user4 >> 1;
   assign dst.t_dest  = user4[0] ? DEST_WIDTH'(CHAIN_ID) : '0;
   assign dst.t_id    = '0;

   // Stage occupancy, the output last flag, and the frame counter.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         v1          <= 1'b0;
         v2          <= 1'b0;
         v3          <= 1'b0;
         v4          <= 1'b0;
         last4       <= 1'b0;
         frame_count <= 16'd0;
      end else begin
         v1 <= src_acc ? 1'b1 : (adv1 ? 1'b0 : v1);
         v2 <= adv1    ? 1'b1 : (adv2 ? 1'b0 : v2);
         v3 <= adv2    ? 1'b1 : (adv3 ? 1'b0 : v3);
         v4 <= adv3    ? 1'b1 : (out_hs ? 1'b0 : v4);
         if (adv3)
            last4 <= side3.last;
         if (out_hs && last4)
            frame_count <= frame_count + 16'd1;
      end
   end

   // S1: capture the beat, remove the offsets, and latch the mode and sidebands.
   always_ff @(posedge aclk) begin
      if (src_acc) begin
         side1 <= '{mode, src.t_last, src.t_user, src.t_keep, src.t_strb};
         for (int i = 0; i < PIXELS; i++) begin
            y1[i] <= src.t_data[32*i+16 +: 8];
            c1[i] <= $signed({24'd0, src.t_data[32*i+16 +: 8]}) - yoff;
            d1[i] <= $signed({24'd0, src.t_data[32*i+8 +: 8]}) - 32'sd128;
            e1[i] <= $signed({24'd0, src.t_data[32*i +: 8]}) - 32'sd128;
         end
      end
   end

   // S2: form the coefficient products of the beat's own matrix.
   always_ff @(posedge aclk) begin
      if (adv1) begin
         side2 <= side1;
         for (int i = 0; i < PIXELS; i++) begin
            y2[i]  <= y1[i];
            yc2[i] <= k2.ky  * c1[i];
            re2[i] <= k2.kre * e1[i];
            gu2[i] <= k2.kgu * d1[i];
            ge2[i] <= k2.kge * e1[i];
            bu2[i] <= k2.kbu * d1[i];
         end
      end
   end

   // S3: sum the products, round, and scale down by 256.
   always_ff @(posedge aclk) begin
      if (adv2) begin
         side3 <= side2;
         for (int i = 0; i < PIXELS; i++) begin
            y3[i] <= y2[i];
            r3[i] <= (yc2[i] + re2[i] + 32'sd128) >>> 8;
            g3[i] <= (yc2[i] - gu2[i] - ge2[i] + 32'sd128) >>> 8;
            b3[i] <= (yc2[i] + bu2[i] + 32'sd128) >>> 8;
         end
      end
   end

   // S4: clamp to 8 bits, or pass luma straight through in bypass mode.
   always_ff @(posedge aclk) begin
      if (adv3) begin
         user4 <= side3.user;
         keep4 <= side3.keep;
         strb4 <= side3.strb;
         for (int i = 0; i < PIXELS; i++) begin
            if (side3.mode == 2'd3)
               data4[32*i +: 32] <= {ALPHA, y3[i], y3[i], y3[i]};
            else
               data4[32*i +: 32] <= {ALPHA, clamp8(r3[i]), clamp8(g3[i]), clamp8(b3[i])};
         end
      end
   end
endmodule

// File: tb/tb_yuv_to_rgb_convert.sv
// Directed and random stimulus for yuv_to_rgb_convert with a scoreboard of expected beats.
module tb_yuv_to_rgb_convert;
   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [15:0] frame_count;

   nasti_stream_channel #(.DATA_WIDTH(64), .USER_WIDTH(2), .DEST_WIDTH(2)) src_if ();
   nasti_stream_channel #(.DATA_WIDTH(64), .USER_WIDTH(2), .DEST_WIDTH(2)) dst_if ();

   yuv_to_rgb_convert #(
      .DATA_WIDTH(64), .USER_WIDTH(2), .DEST_WIDTH(2), .CHAIN_ID(2), .ALPHA(8'hFF)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .mode        (mode),
      .src         (src_if.slave),
      .dst         (dst_if.master),
      .frame_count (frame_count)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      logic [63:0] data;
      logic [63:0] mask;
      logic        last;
      logic [1:0]  user;
      logic [1:0]  dest;
      logic [7:0]  keep;
   } exp_t;

   exp_t q[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   cyc = 0;
   int   hs_cyc = 0;
   int   inflight = 0;
   logic chk_rdy = 1'b0;
   logic rand_rdy = 1'b0;
   logic rdy_val = 1'b1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] clamp(input int x);
      logic [7:0] r;
      if (x < 0) r = 8'h00;
      else if (x > 255) r = 8'hFF;
      else r = x[7:0];
      return r;
   endfunction

   // Reference conversion of one lane, straight from the matrix formulas.
   function automatic logic [31:0] model_lane(input logic [31:0] ln, input logic [1:0] m);
      int y, u, v, c, d, e, ky, kre, kgu, kge, kbu, r, g, b;
      y = {24'd0, ln[23:16]};
      u = {24'd0, ln[15:8]};
      v = {24'd0, ln[7:0]};
      if (m == 2'd3) return {8'hFF, ln[23:16], ln[23:16], ln[23:16]};
      case (m)
         2'd0:    begin ky = 298; kre = 409; kgu = 100; kge = 208; kbu = 516; end
         2'd1:    begin ky = 298; kre = 459; kgu = 55;  kge = 136; kbu = 541; end
         default: begin ky = 256; kre = 359; kgu = 88;  kge = 183; kbu = 454; end
      endcase
      c = y - ((m == 2'd2) ? 0 : 16);
      d = u - 128;
      e = v - 128;
      r = (ky * c + kre * e + 128) >>> 8;
      g = (ky * c - kgu * d - kge * e + 128) >>> 8;
      b = (ky * c + kbu * d + 128) >>> 8;
      return {8'hFF, clamp(r), clamp(g), clamp(b)};
   endfunction

   always @(posedge aclk) cyc <= cyc + 1;

   // Output ready pattern, changed just after each rising edge.
   always @(posedge aclk) begin
      #1;
      dst_if.t_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_val;
   end

   // Monitor: src.t_ready against pipeline occupancy, and dst beats against the scoreboard.
   always @(negedge aclk) begin
      if (aresetn) begin
         if (chk_rdy) begin
            check("src_ready_vs_full", {63'd0, src_if.t_ready},
                  {63'd0, !(inflight == 4 && !dst_if.t_ready)});
            inflight = inflight + int'(src_if.t_valid && src_if.t_ready)
                                - int'(dst_if.t_valid && dst_if.t_ready);
         end
         if (dst_if.t_valid && dst_if.t_ready) begin
            if (q.size() == 0) begin
               check("stray_beat", 64'(q.size()), 64'd1);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("data", dst_if.t_data & e.mask, e.data & e.mask);
               check("last", {63'd0, dst_if.t_last}, {63'd0, e.last});
               check("user", {62'd0, dst_if.t_user}, {62'd0, e.user});
               check("dest", {62'd0, dst_if.t_dest}, {62'd0, e.dest});
               check("keep_strb", {48'd0, dst_if.t_keep, dst_if.t_strb}, {48'd0, e.keep, e.keep});
            end
         end
      end
   end

   task automatic send(input logic [63:0] d, input logic [1:0] m, input logic lst,
                       input logic [1:0] usr, input logic [7:0] kp, input logic [63:0] exp_d);
      exp_t e;
      int   n;
      src_if.t_valid = 1'b1;
      src_if.t_data  = d;
      src_if.t_last  = lst;
      src_if.t_user  = usr;
      src_if.t_keep  = kp;
      src_if.t_strb  = kp;
      mode           = m;
      n = 0;
      @(negedge aclk);
      while (!src_if.t_ready && n < 100) begin
         n++;
         @(negedge aclk);
      end
      if (!src_if.t_ready) check("src_accept_timeout", {63'd0, src_if.t_ready}, 64'd1);
      hs_cyc = cyc;
      e.data = exp_d;
      for (int b = 0; b < 8; b++) e.mask[8*b +: 8] = {8{kp[b]}};
      e.last = lst;
      e.user = usr >> 1;
      e.dest = usr[0] ? 2'd2 : 2'd0;
      e.keep = kp;
      q.push_back(e);
      @(posedge aclk);
      #1;
      src_if.t_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         @(negedge aclk);
         n++;
      end
      if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
      @(negedge aclk);
      @(posedge aclk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] rd;
      logic [1:0]  rm;
      logic [1:0]  ru;
      src_if.t_valid = 1'b0;
      src_if.t_data  = '0;
      src_if.t_last  = 1'b0;
      src_if.t_user  = '0;
      src_if.t_keep  = '0;
      src_if.t_strb  = '0;
      src_if.t_id    = '0;
      src_if.t_dest  = '0;

      // Reset state
      repeat (2) @(negedge aclk);
      check("rst_dst_valid", {63'd0, dst_if.t_valid}, 64'd0);
      check("rst_dst_last", {63'd0, dst_if.t_last}, 64'd0);
      check("rst_frame_count", {48'd0, frame_count}, 64'd0);
      aresetn = 1'b1;
      @(posedge aclk);
      #1;
      check("rst_src_ready", {63'd0, src_if.t_ready}, 64'd1);

      // Black with latency measurement; lane 1 top byte must be ignored
      send(64'hAB108080_00108080, 2'd0, 1'b0, 2'd0, 8'hFF, 64'hFF000000_FF000000);
      do @(negedge aclk); while (!dst_if.t_valid && (cyc - hs_cyc) < 20);
      check("latency", 64'(cyc - hs_cyc), 64'd4);
      @(posedge aclk);
      #1;

      // Back-to-back beats, mode switched every beat
      send(64'h00EB8080_00515AF0, 2'd0, 1'b0, 2'd0, 8'hFF, 64'hFFFFFFFF_FFFF0000);
      send(64'h0000FF00_00808080, 2'd2, 1'b0, 2'd0, 8'hFF, 64'hFF0030E1_FF808080);
      send(64'h005A00FF_005A00FF, 2'd3, 1'b0, 2'd2, 8'hFF, 64'hFF5A5A5A_FF5A5A5A);
      send(64'h00808080_00515AF0, 2'd1, 1'b0, 2'd1, 8'hFF, 64'hFF828282_FFFF1800);
      send(64'h12345678_00EB8080, 2'd0, 1'b0, 2'd0, 8'h0F, 64'h00000000_FFFFFFFF);
      drain();

      // Random beats with random output backpressure
      inflight = 0;
      chk_rdy  = 1'b1;
      rand_rdy = 1'b1;
      for (int i = 0; i < 100; i++) begin
         rd = {$urandom, $urandom};
         rm = 2'($urandom_range(0, 3));
         ru = 2'($urandom_range(0, 3));
         send(rd, rm, 1'b0, ru, 8'hFF,
              {model_lane(rd[63:32], rm), model_lane(rd[31:0], rm)});
      end
      chk_rdy  = 1'b0;
      rand_rdy = 1'b0;
      rdy_val  = 1'b1;
      drain();

      // Frame counting with chain routing, last on beats 5 and 9
      for (int i = 1; i <= 10; i++) begin
         rd = {32'h00808080, 32'h00108080};
         send(rd, 2'd0, (i == 5 || i == 9), 2'd3, 8'hFF, 64'hFF828282_FF000000);
         if (i == 5) begin
            drain();
            check("frame_count_1", {48'd0, frame_count}, 64'd1);
         end
      end
      drain();
      check("frame_count_2", {48'd0, frame_count}, 64'd2);

      // Reset with three beats in flight
      rdy_val = 1'b0;
      @(posedge aclk);
      #1;
      send(64'h00108080_00108080, 2'd0, 1'b1, 2'd0, 8'hFF, 64'hFF000000_FF000000);
      send(64'h00808080_00808080, 2'd2, 1'b1, 2'd0, 8'hFF, 64'hFF808080_FF808080);
      send(64'h005A00FF_005A00FF, 2'd3, 1'b1, 2'd0, 8'hFF, 64'hFF5A5A5A_FF5A5A5A);
      repeat (4) @(negedge aclk);
      check("inflight_valid", {63'd0, dst_if.t_valid}, 64'd1);
      @(posedge aclk);
      #3;
      aresetn = 1'b0;
      #1;
      check("async_rst_valid", {63'd0, dst_if.t_valid}, 64'd0);
      check("async_rst_frames", {48'd0, frame_count}, 64'd0);
      q.delete();
      rdy_val = 1'b1;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      #1;
      check("post_rst_src_ready", {63'd0, src_if.t_ready}, 64'd1);
      repeat (10) @(negedge aclk);
      check("post_rst_no_beats", {63'd0, dst_if.t_valid}, 64'd0);
      @(posedge aclk);
      #1;

      // Frame counter wrap from all-ones
      force dut.frame_count = 16'hFFFF;
      @(negedge aclk);
      release dut.frame_count;
      @(posedge aclk);
      #1;
      send(64'h00EB8080_00EB8080, 2'd0, 1'b1, 2'd0, 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
      drain();
      check("frame_count_wrap", {48'd0, frame_count}, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
